// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access sequencer:
// op encodings, FSM states and request-size decode.
package dm_pkg;

    localparam int DM_DEPTH = 64;
    localparam int DM_AW    = 6;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_SW  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_SB  = 3'b110;
    localparam logic [2:0] OP_SH  = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Number of bytes moved by an op: 1, 2 or 4.
    function automatic logic [2:0] op_size(input logic [2:0] op);
        logic [2:0] n;
        n = 3'd1;
        unique case (op)
            OP_LB, OP_LBU, OP_SB: n = 3'd1;
            OP_LH, OP_LHU, OP_SH: n = 3'd2;
            OP_LW, OP_SW:         n = 3'd4;
            default:              n = 3'd1;
        endcase
        return n;
    endfunction

    function automatic logic op_is_store(input logic [2:0] op);
        return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of the assembled load accumulator
// according to the load op.
import dm_pkg::*;

module load_extend (
    input  logic [2:0]  i_op,
    input  logic [31:0] i_acc,
    output logic [31:0] o_ext
);

    // Pick extension from the op; word loads pass straight through.
    always_comb begin
        o_ext = i_acc;
        unique case (i_op)
            OP_LB:   o_ext = {{24{i_acc[7]}}, i_acc[7:0]};
            OP_LH:   o_ext = {{16{i_acc[15]}}, i_acc[15:0]};
            OP_LBU:  o_ext = {24'd0, i_acc[7:0]};
            OP_LHU:  o_ext = {16'd0, i_acc[15:0]};
            default: o_ext = i_acc;
        endcase
    end

endmodule

// File: rtl/dm_access_unit.sv
// Multi-cycle byte-serial load/store sequencer between execute
// and the big-endian byte-wide data memory.
import dm_pkg::*;

module dm_access_unit #(
    parameter int DEPTH = DM_DEPTH,
    parameter int AW    = DM_AW
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [31:0]   DAddr,
    input  logic [31:0]   DataIn,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [31:0]   DataOut,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    state_t        r_state;
    state_t        w_next;
    logic [2:0]    r_op;
    logic [31:0]   r_data;
    logic [2:0]    r_n;
    logic [1:0]    r_k;
    logic [AW-1:0] r_mem_addr;
    logic [31:0]   r_acc;
    logic [31:0]   r_dout;
    logic          r_err;

    logic [2:0]    w_size;
    logic [32:0]   w_end;
    logic          w_mis;
    logic          w_oor;
    logic          w_bad;
    logic          w_last;
    logic          w_store;
    logic [1:0]    w_idx;
    logic [31:0]   w_acc_next;
    logic [31:0]   w_ext;

    assign w_size  = op_size(op);
    // Last byte address, one bit wider so a 32-bit wrap cannot hide it.
    assign w_end   = {1'b0, DAddr} + {30'd0, w_size} - 33'd1;
    assign w_oor   = w_end > 33'(DEPTH - 1);
    assign w_mis   = ((w_size == 3'd2) && DAddr[0]) ||
                     ((w_size == 3'd4) && (DAddr[1:0] != 2'b00));
    assign w_bad   = w_mis || w_oor;

    assign w_store = op_is_store(r_op);
    assign w_last  = ({1'b0, r_k} == (r_n - 3'd1));
    // Big-endian: first access carries the most significant byte.
    assign w_idx   = r_n[1:0] - 2'd1 - r_k;
    assign w_acc_next = {r_acc[23:0], mem_rdata};

    load_extend u_ext (
        .i_op  (r_op),
        .i_acc (w_acc_next),
        .o_ext (w_ext)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (Reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = w_bad ? DONE : ACCESS;
            ACCESS:  if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Store byte selection from the latched store data.
    always_comb begin
        mem_wdata = r_data[7:0];
        unique case (w_idx)
            2'd0: mem_wdata = r_data[7:0];
            2'd1: mem_wdata = r_data[15:8];
            2'd2: mem_wdata = r_data[23:16];
            2'd3: mem_wdata = r_data[31:24];
            default: mem_wdata = r_data[7:0];
        endcase
    end

    // Request latch, byte counter, address walk and load assembly.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_op       <= OP_LB;
            r_data     <= 32'd0;
            r_n        <= 3'd1;
            r_k        <= 2'd0;
            r_mem_addr <= '0;
            r_acc      <= 32'd0;
            r_dout     <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op   <= op;
                        r_data <= DataIn;
                        r_n    <= w_size;
                        r_k    <= 2'd0;
                        r_acc  <= 32'd0;
                        r_err  <= w_bad;
                        if (!w_bad)
                            r_mem_addr <= DAddr[AW-1:0];
                    end
                end
                ACCESS: begin
                    r_acc <= w_acc_next;
                    if (w_last) begin
                        if (!w_store)
                            r_dout <= w_ext;
                    end else begin
                        r_k        <= r_k + 2'd1;
                        r_mem_addr <= r_mem_addr + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign err      = r_err;
    assign DataOut  = r_dout;
    assign mem_addr = r_mem_addr;
    assign mem_we   = (r_state == ACCESS) && w_store;

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed scoreboard bench for dm_access_unit with a 64x8
// byte RAM model (combinational read, clocked write).
module tb_dm_access_unit;
    import dm_pkg::*;

    logic        CLK;
    logic        Reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] DAddr;
    logic [31:0] DataIn;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] DataOut;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0] ram [0:63];
    int checks = 0;
    int errors = 0;
    int we_cnt = 0;

    typedef struct {
        string       tag;
        logic [31:0] dout;
        logic        err;
        int          lat;
    } exp_t;
    exp_t q[$];

    dm_access_unit #(.DEPTH(64), .AW(6)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .start     (start),
        .op        (op),
        .DAddr     (DAddr),
        .DataIn    (DataIn),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .DataOut   (DataOut),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign mem_rdata = ram[mem_addr];

    always @(posedge CLK) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] d, input string tag,
                       input logic [31:0] ed, input logic ee,
                       input int el);
        exp_t e;
        int cyc;
        int we0;
        e.tag = tag; e.dout = ed; e.err = ee; e.lat = el;
        q.push_back(e);
        @(posedge CLK); #1;
        start = 1'b1; op = o; DAddr = a; DataIn = d;
        we0 = we_cnt;
        @(posedge CLK); #1;
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 12) begin
            @(posedge CLK); #1;
            cyc++;
        end
        e = q.pop_front();
        chk({e.tag, "_lat"}, 32'(cyc), 32'(e.lat));
        chk({e.tag, "_dout"}, DataOut, e.dout);
        chk({e.tag, "_err"}, {31'd0, err}, {31'd0, e.err});
        chk({e.tag, "_busy"}, {31'd0, busy}, 32'd1);
        if (e.err)
            chk({e.tag, "_nowrite"}, 32'(we_cnt - we0), 32'd0);
        @(posedge CLK); #1;
        chk({e.tag, "_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        int dcnt;
        int c2;
        logic [31:0] w3c;

        for (int i = 0; i < 64; i++) ram[i] = init_byte(i);
        Reset = 1'b1; start = 1'b0; op = OP_LB;
        DAddr = 32'd0; DataIn = 32'd0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_dout", DataOut, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", {26'd0, mem_addr}, 32'd0);
        Reset = 1'b0;

        req(OP_SW, 32'h08, 32'hA1B2C3D4, "sw08", 32'd0, 1'b0, 5);
        chk("ram08", {24'd0, ram[8]}, 32'hA1);
        chk("ram09", {24'd0, ram[9]}, 32'hB2);
        chk("ram0a", {24'd0, ram[10]}, 32'hC3);
        chk("ram0b", {24'd0, ram[11]}, 32'hD4);

        req(OP_LB, 32'h09, 32'd0, "lb09", 32'hFFFFFFB2, 1'b0, 2);
        req(OP_LBU, 32'h09, 32'd0, "lbu09", 32'h000000B2, 1'b0, 2);
        req(OP_SH, 32'h02, 32'h00008001, "sh02", 32'h000000B2, 1'b0, 3);
        chk("ram02", {24'd0, ram[2]}, 32'h80);
        chk("ram03", {24'd0, ram[3]}, 32'h01);
        req(OP_LH, 32'h02, 32'd0, "lh02", 32'hFFFF8001, 1'b0, 3);
        req(OP_LHU, 32'h02, 32'd0, "lhu02", 32'h00008001, 1'b0, 3);
        req(OP_SB, 32'h3F, 32'h000000E7, "sb3f", 32'h00008001, 1'b0, 2);
        chk("ram3f", {24'd0, ram[63]}, 32'hE7);

        req(OP_LW, 32'h06, 32'd0, "lw06_mis", 32'h00008001, 1'b1, 1);
        req(OP_SW, 32'h3E, 32'h12345678, "sw3e_oor", 32'h00008001, 1'b1, 1);
        chk("ram3e_keep", {24'd0, ram[62]}, {24'd0, init_byte(62)});
        chk("ram3f_keep", {24'd0, ram[63]}, 32'hE7);
        req(OP_LH, 32'hFFFFFFFF, 32'd0, "lhwrap_mis", 32'h00008001, 1'b1, 1);
        req(OP_LB, 32'h00000040, 32'd0, "lb40_oor", 32'h00008001, 1'b1, 1);

        w3c = {ram[60], ram[61], ram[62], ram[63]};
        req(OP_LW, 32'h3C, 32'd0, "lw3c", w3c, 1'b0, 5);
        chk("err_clear", {31'd0, err}, 32'd0);

        // start held high: one done per request, re-accept only from IDLE
        for (int i = 0; i < 2; i++) begin
            e.tag = "held"; e.dout = 32'hA1B2C3D4; e.err = 1'b0; e.lat = 5;
            q.push_back(e);
        end
        @(posedge CLK); #1;
        start = 1'b1; op = OP_LW; DAddr = 32'h08;
        @(posedge CLK); #1;
        dcnt = 0;
        for (int c = 1; c <= 6; c++) begin
            if (done === 1'b1) begin
                dcnt++;
                e = q.pop_front();
                chk("held_lat", 32'(c), 32'(e.lat));
                chk("held_dout", DataOut, e.dout);
            end
            if (c == 6)
                chk("held_idle", {31'd0, busy}, 32'd0);
            if (c < 6) begin
                @(posedge CLK); #1;
            end
        end
        chk("held_once", 32'(dcnt), 32'd1);
        @(posedge CLK); #1;
        start = 1'b0;
        chk("held_reacc", {31'd0, busy}, 32'd1);
        c2 = 1;
        while (done !== 1'b1 && c2 < 12) begin
            @(posedge CLK); #1;
            c2++;
        end
        e = q.pop_front();
        chk("held2_lat", 32'(c2), 32'(e.lat));
        chk("held2_dout", DataOut, e.dout);
        @(posedge CLK); #1;

        // reset mid-store after the second byte
        @(posedge CLK); #1;
        start = 1'b1; op = OP_SW; DAddr = 32'h10; DataIn = 32'h11223344;
        @(posedge CLK); #1;
        start = 1'b0;
        @(posedge CLK); #1;
        Reset = 1'b1;
        @(posedge CLK); #1;
        Reset = 1'b0;
        chk("rst_sw_busy", {31'd0, busy}, 32'd1 - 32'd1);
        chk("rst_sw_done", {31'd0, done}, 32'd0);
        chk("rst_sw_we", {31'd0, mem_we}, 32'd0);
        repeat (3) @(posedge CLK);
        #1;
        chk("ram10", {24'd0, ram[16]}, 32'h11);
        chk("ram11", {24'd0, ram[17]}, 32'h22);
        chk("ram12", {24'd0, ram[18]}, {24'd0, init_byte(18)});
        chk("ram13", {24'd0, ram[19]}, {24'd0, init_byte(19)});
        chk("ram_nodone", {31'd0, done}, 32'd0);

        // reset mid-load clears DataOut
        @(posedge CLK); #1;
        start = 1'b1; op = OP_LW; DAddr = 32'h08;
        @(posedge CLK); #1;
        start = 1'b0;
        Reset = 1'b1;
        @(posedge CLK); #1;
        Reset = 1'b0;
        chk("rst_lw_dout", DataOut, 32'd0);
        chk("rst_lw_busy", {31'd0, busy}, 32'd0);

        // reset together with start drops the request
        @(posedge CLK); #1;
        start = 1'b1; Reset = 1'b1; op = OP_LB; DAddr = 32'h09;
        @(posedge CLK); #1;
        start = 1'b0; Reset = 1'b0;
        chk("rst_start_busy", {31'd0, busy}, 32'd0);
        @(posedge CLK); #1;
        chk("rst_start_busy2", {31'd0, busy}, 32'd0);
        chk("rst_start_dout", DataOut, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
